// File: rtl/checksum_arbiter_pkg.sv
// Shared types and limits for the checksum calculator arbiter.
// The FSM encoding is fixed at 3 bits so that waveforms decode consistently.
package checksum_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_STREAM      = 3'd1,
    S_WAIT_RESULT = 3'd2,
    S_FLUSH       = 3'd3,
    S_DISCARD     = 3'd4,
    S_RELEASE     = 3'd5
  } state_type;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int MAX_REQUESTERS         = 8;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin choice: the lowest set request at or above rr_pointer_i,
// falling back to the lowest set request overall when nothing is set at or above it.
module round_robin_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     request_i,
  input  logic [IDX_W-1:0] rr_pointer_i,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] index_o
);

  logic [N-1:0] masked;
  logic [N-1:0] src;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = request_i[i] && (IDX_W'(i) >= rr_pointer_i);
    end
    src = (|masked) ? masked : request_i;

    // Scanning downwards leaves the lowest set bit as the winner.
    pick_o  = '0;
    index_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) begin
        pick_o    = '0;
        pick_o[i] = 1'b1;
        index_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/checksum_arbiter.sv
// Round-robin owner of one byte-serial checksum calculator; bytes are forwarded with one register
// of latency, and a watchdog aborts owners that stall, flushing the calculator with a final zero byte.
module checksum_arbiter
  import checksum_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQUESTERS-1:0]     request,
  output logic [NUM_REQUESTERS-1:0]     grant,
  input  logic [8*NUM_REQUESTERS-1:0]   req_data,
  input  logic [NUM_REQUESTERS-1:0]     req_data_enable,
  input  logic [NUM_REQUESTERS-1:0]     req_data_last,
  output logic [15:0]                   result,
  output logic [NUM_REQUESTERS-1:0]     result_valid,
  output logic [NUM_REQUESTERS-1:0]     result_error,
  output logic                          busy,
  output logic [7:0]                    calc_data,
  output logic                          calc_data_enable,
  output logic                          calc_data_last,
  input  logic [15:0]                   calc_result,
  input  logic                          calc_result_valid,
  input  logic                          calc_ready
);

  localparam int N     = NUM_REQUESTERS;
  localparam int IDX_W = $clog2(NUM_REQUESTERS);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  state_type         state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [7:0]        calc_data_q, calc_data_d;
  logic              calc_en_q, calc_en_d;
  logic              calc_last_q, calc_last_d;
  logic [15:0]       result_q, result_d;
  logic [N-1:0]      res_vld_q, res_vld_d;
  logic [N-1:0]      res_err_q, res_err_d;

  logic [N-1:0]      pick;
  logic [IDX_W-1:0]  pick_idx;
  logic [7:0]        sel_dat;
  logic              sel_en;
  logic              sel_last;
  logic [WD_W-1:0]   wdog_inc;
  logic              wdog_expired;

  round_robin_picker #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_picker (
    .request_i    (request),
    .rr_pointer_i (rr_ptr_q),
    .pick_o       (pick),
    .index_o      (pick_idx)
  );

  // Only the owner's lane reaches the calculator; other clients' enables are invisible.
  always_comb begin
    sel_dat  = '0;
    sel_en   = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        sel_dat  = req_data[8*i +: 8];
        sel_en   = req_data_enable[i];
        sel_last = req_data_last[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    wdog_d       = wdog_q;
    calc_data_d  = calc_data_q;
    calc_en_d    = 1'b0;
    calc_last_d  = 1'b0;
    result_d     = result_q;
    res_vld_d    = '0;
    res_err_d    = '0;
    wdog_inc     = (wdog_q == '1) ? wdog_q : wdog_q + WD_W'(1);
    wdog_expired = (wdog_q == WD_LIMIT);

    case (state_q)
      S_IDLE: begin
        if (calc_ready && (|request)) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          wdog_d  = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (sel_en) begin
          calc_data_d = sel_dat;
          calc_en_d   = 1'b1;
          calc_last_d = sel_last;
          wdog_d      = '0;
          if (sel_last) state_d = S_WAIT_RESULT;
        end else if (wdog_expired) begin
          state_d = S_FLUSH;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_WAIT_RESULT: begin
        if (calc_result_valid) begin
          result_d  = calc_result;
          res_vld_d = grant_q;
          state_d   = S_RELEASE;
        end else if (wdog_expired) begin
          res_err_d = grant_q;
          state_d   = S_RELEASE;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_FLUSH: begin
        // A terminating zero byte closes the half-finished message inside the calculator.
        calc_data_d = 8'h00;
        calc_en_d   = 1'b1;
        calc_last_d = 1'b1;
        state_d     = S_DISCARD;
      end
      S_DISCARD: begin
        if (calc_result_valid) begin
          res_err_d = grant_q;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        grant_d  = '0;
        rr_ptr_d = (gidx_q == IDX_W'(N - 1)) ? '0 : gidx_q + IDX_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      wdog_q      <= '0;
      calc_data_q <= '0;
      calc_en_q   <= 1'b0;
      calc_last_q <= 1'b0;
      result_q    <= '0;
      res_vld_q   <= '0;
      res_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      wdog_q      <= wdog_d;
      calc_data_q <= calc_data_d;
      calc_en_q   <= calc_en_d;
      calc_last_q <= calc_last_d;
      result_q    <= result_d;
      res_vld_q   <= res_vld_d;
      res_err_q   <= res_err_d;
    end
  end

  assign grant            = grant_q;
  assign result           = result_q;
  assign result_valid     = res_vld_q;
  assign result_error     = res_err_q;
  assign busy             = (state_q != S_IDLE);
  assign calc_data        = calc_data_q;
  assign calc_data_enable = calc_en_q;
  assign calc_data_last   = calc_last_q;

endmodule

// File: tb/tb_checksum_arbiter.sv
// Directed bench for checksum_arbiter with a behavioural byte-serial checksum calculator attached.
module tb_checksum_arbiter;

  localparam int N   = 4;
  localparam int TMO = 1024;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   request, grant, req_data_enable, req_data_last, result_valid, result_error;
  logic [8*N-1:0] req_data;
  logic [15:0]    result, calc_result;
  logic           busy, calc_data_enable, calc_data_last, calc_result_valid, calc_ready;
  logic [7:0]     calc_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  checksum_arbiter #(.NUM_REQUESTERS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clock             (clock),
    .reset             (reset),
    .request           (request),
    .grant             (grant),
    .req_data          (req_data),
    .req_data_enable   (req_data_enable),
    .req_data_last     (req_data_last),
    .result            (result),
    .result_valid      (result_valid),
    .result_error      (result_error),
    .busy              (busy),
    .calc_data         (calc_data),
    .calc_data_enable  (calc_data_enable),
    .calc_data_last    (calc_data_last),
    .calc_result       (calc_result),
    .calc_result_valid (calc_result_valid),
    .calc_ready        (calc_ready)
  );

  // Behavioural calculator: big-endian 16-bit words, odd trailing byte in the high half.
  logic [31:0] m_acc;
  logic [7:0]  m_hi;
  logic        m_odd, m_pend;

  function automatic logic [15:0] fold(input logic [31:0] a);
    logic [16:0] s;
    s = {1'b0, a[15:0]} + {1'b0, a[31:16]};
    s = {1'b0, s[15:0]} + {16'b0, s[16]};
    return s[15:0];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_acc <= '0; m_hi <= '0; m_odd <= 1'b0; m_pend <= 1'b0;
      calc_result <= '0; calc_result_valid <= 1'b0;
    end else begin
      calc_result_valid <= 1'b0;
      if (m_pend) begin
        calc_result       <= fold(m_acc);
        calc_result_valid <= 1'b1;
        m_pend <= 1'b0; m_acc <= '0; m_odd <= 1'b0;
      end else if (calc_data_enable) begin
        if (!m_odd) begin
          if (calc_data_last) begin
            m_acc  <= m_acc + {16'h0, calc_data, 8'h00};
            m_pend <= 1'b1;
          end else begin
            m_hi  <= calc_data;
            m_odd <= 1'b1;
          end
        end else begin
          m_acc <= m_acc + {16'h0, m_hi, calc_data};
          m_odd <= 1'b0;
          if (calc_data_last) m_pend <= 1'b1;
        end
      end
    end
  end
  assign calc_ready = !m_pend && !calc_result_valid;

  // Observation of the calculator stream and the per-client pulses.
  logic [7:0] seen_dat[$];
  logic       seen_last[$];
  int         vld_cnt[N];
  int         err_cnt[N];

  always @(negedge clock) begin
    if (calc_data_enable) begin
      seen_dat.push_back(calc_data);
      seen_last.push_back(calc_data_last);
    end
    if ((|result_valid) || (|result_error)) begin
      checks++;
      if ((result_valid & result_error) != '0 || ((result_valid | result_error) & ~grant) != '0
          || $countones(result_valid | result_error) != 1) begin
        errors++;
        $display("FAIL pulse_owner: result_valid=%b result_error=%b grant=%b, required one pulse on the granted index",
                 result_valid, result_error, grant);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (result_valid[i]) vld_cnt[i]++;
      if (result_error[i]) err_cnt[i]++;
    end
  end

  function automatic logic [31:0] seen_bytes();
    logic [31:0] v = '0;
    foreach (seen_dat[i]) v = {v[23:0], seen_dat[i]};
    return v;
  endfunction

  function automatic logic [3:0] seen_lasts();
    logic [3:0] v = '0;
    foreach (seen_last[i]) v = {v[2:0], seen_last[i]};
    return v;
  endfunction

  // Stimulus helpers, all entered and left on a falling edge (or just after one).
  task automatic wait_grant(input int c, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (grant[c]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_any_grant(output int idx, output bit ok);
    bit saw_zero = 1'b0;
    ok = 1'b0; idx = -1;
    for (int t = 0; t < 50; t++) begin
      if (grant == '0) saw_zero = 1'b1;
      else if (saw_zero) begin
        for (int i = 0; i < N; i++) if (grant[i]) idx = i;
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic send_msg(input int c, input logic [31:0] bytes, input int n, input bit with_last);
    for (int k = 0; k < n; k++) begin
      req_data[8*c +: 8]  = bytes[8*(n-1-k) +: 8];
      req_data_enable[c]  = 1'b1;
      req_data_last[c]    = with_last && (k == n - 1);
      @(negedge clock);
    end
    req_data_enable[c] = 1'b0;
    req_data_last[c]   = 1'b0;
  endtask

  task automatic wait_outcome(input int c, input int limit, output bit v, output bit e);
    int v0 = vld_cnt[c];
    int e0 = err_cnt[c];
    v = 1'b0; e = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clock); #1;
      if (vld_cnt[c] != v0) v = 1'b1;
      if (err_cnt[c] != e0) e = 1'b1;
      if (v || e) break;
    end
  endtask

  task automatic test_reset();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b, expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if ({result_valid, result_error} !== 8'h00) begin errors++;
      $display("FAIL reset_pulses: got %b/%b, expected 0000/0000", result_valid, result_error); end
    checks++; if ({calc_data_enable, calc_data_last, calc_data} !== 10'h0) begin errors++;
      $display("FAIL reset_calc: got en=%b last=%b data=%h, expected 0/0/00", calc_data_enable, calc_data_last, calc_data); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h, expected 0000", result); end
  endtask

  task automatic test_basic();
    bit v, e;
    seen_dat.delete(); seen_last.delete();
    request[0] = 1'b1;
    @(negedge clock);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL basic_grant_latency: got %b, expected 0001", grant); end
    request[0] = 1'b0;
    req_data[7:0] = 8'h45; req_data_enable[0] = 1'b1; req_data_last[0] = 1'b0;
    @(negedge clock);
    checks++; if ({calc_data_enable, calc_data} !== 9'h145) begin errors++;
      $display("FAIL basic_forward_latency: got en=%b data=%h, expected 1/45", calc_data_enable, calc_data); end
    send_msg(0, 32'h0000001C, 3, 1'b1);
    wait_outcome(0, 50, v, e);
    checks++; if (!v || e) begin errors++; $display("FAIL basic_outcome: got valid=%b error=%b, expected 1/0", v, e); end
    checks++; if (result !== 16'h451C) begin errors++; $display("FAIL basic_result: got %h, expected 451c", result); end
    checks++; if (seen_dat.size() != 4 || seen_bytes() !== 32'h4500001C || seen_lasts() !== 4'b0001) begin errors++;
      $display("FAIL basic_stream: got %0d bytes %h lasts %b, expected 4 bytes 4500001c lasts 0001",
               seen_dat.size(), seen_bytes(), seen_lasts()); end
  endtask

  task automatic test_odd_length();
    bit v, e, ok;
    int v_before = vld_cnt[2];
    seen_dat.delete(); seen_last.delete();
    request[2] = 1'b1;
    wait_grant(2, ok);
    checks++; if (!ok || grant !== 4'b0100) begin errors++; $display("FAIL odd_grant: got %b, expected 0100", grant); end
    request[2] = 1'b0;
    send_msg(2, 32'h00010203, 3, 1'b1);
    wait_outcome(2, 50, v, e);
    checks++; if (!v || e || result !== 16'h0402) begin errors++;
      $display("FAIL odd_result: got valid=%b error=%b result=%h, expected 1/0/0402", v, e, result); end
    repeat (3) @(negedge clock);
    checks++; if (vld_cnt[2] != v_before + 1) begin errors++;
      $display("FAIL odd_single_pulse: got %0d pulses, expected 1", vld_cnt[2] - v_before); end
    checks++; if (seen_dat.size() != 3 || seen_bytes() !== 32'h00010203 || seen_lasts() !== 4'b0001) begin errors++;
      $display("FAIL odd_stream: got %0d bytes %h lasts %b, expected 3 bytes 010203 lasts 001",
               seen_dat.size(), seen_bytes(), seen_lasts()); end
  endtask

  task automatic test_ignore_others();
    bit v, e, ok;
    seen_dat.delete(); seen_last.delete();
    request[3] = 1'b1;
    wait_grant(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignore_grant: got %b, expected 1000", grant); end
    request[3] = 1'b0;
    fork
      begin
        send_msg(3, 32'h00001020, 2, 1'b1);
        wait_outcome(3, 50, v, e);
      end
      begin
        req_data[7:0] = 8'hEE;
        for (int t = 0; t < 8; t++) begin
          req_data_enable[0] = ~req_data_enable[0];
          req_data_last[0]   = t[1];
          @(negedge clock);
        end
        req_data_enable[0] = 1'b0;
        req_data_last[0]   = 1'b0;
      end
    join
    checks++; if (!v || e || result !== 16'h1020) begin errors++;
      $display("FAIL ignore_result: got valid=%b error=%b result=%h, expected 1/0/1020", v, e, result); end
    checks++; if (seen_dat.size() != 2 || seen_bytes() !== 32'h00001020 || seen_lasts() !== 4'b0001) begin errors++;
      $display("FAIL ignore_stream: got %0d bytes %h lasts %b, expected 2 bytes 1020 lasts 01",
               seen_dat.size(), seen_bytes(), seen_lasts()); end
  endtask

  task automatic test_round_robin();
    bit v, e, ok;
    int idx;
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_any_grant(idx, ok);
      checks++; if (!ok || idx != k % 4) begin errors++;
        $display("FAIL rr_order_%0d: got client %0d, expected %0d", k, idx, k % 4); end
      if (!ok) break;
      if (k == 4) request = 4'b0000;
      send_msg(idx, 32'h0000FFFF, 2, 1'b1);
      wait_outcome(idx, 50, v, e);
      checks++; if (!v || e || result !== 16'hFFFF) begin errors++;
        $display("FAIL rr_result_%0d: got valid=%b error=%b result=%h, expected 1/0/ffff", k, v, e, result); end
    end
  endtask

  task automatic test_watchdog();
    bit v, e, ok;
    int idx;
    int v_before[N];
    for (int i = 0; i < N; i++) v_before[i] = vld_cnt[i];
    seen_dat.delete(); seen_last.delete();
    request[1] = 1'b1;
    wait_grant(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wd_grant: got %b, expected 0010", grant); end
    request[1] = 1'b0;
    send_msg(1, 32'h000000AB, 1, 1'b0);
    request[2] = 1'b1;
    repeat (TMO - 20) @(negedge clock);
    #1;
    checks++; if (result_error !== 4'b0000 || busy !== 1'b1 || grant !== 4'b0010) begin errors++;
      $display("FAIL wd_early_abort: got error=%b busy=%b grant=%b, expected 0000/1/0010", result_error, busy, grant); end
    wait_outcome(1, 100, v, e);
    checks++; if (v || !e) begin errors++; $display("FAIL wd_outcome: got valid=%b error=%b, expected 0/1", v, e); end
    checks++; if (vld_cnt[0] != v_before[0] || vld_cnt[1] != v_before[1] || vld_cnt[2] != v_before[2]
                  || vld_cnt[3] != v_before[3]) begin errors++;
      $display("FAIL wd_no_valid: got %0d %0d %0d %0d valid pulses, expected 0", vld_cnt[0] - v_before[0],
               vld_cnt[1] - v_before[1], vld_cnt[2] - v_before[2], vld_cnt[3] - v_before[3]); end
    checks++; if (seen_dat.size() != 2 || seen_bytes() !== 32'h0000AB00 || seen_lasts() !== 4'b0001) begin errors++;
      $display("FAIL wd_flush_stream: got %0d bytes %h lasts %b, expected 2 bytes ab00 lasts 01",
               seen_dat.size(), seen_bytes(), seen_lasts()); end
    request[1] = 1'b1;
    wait_any_grant(idx, ok);
    checks++; if (!ok || idx != 2) begin errors++; $display("FAIL wd_next_grant: got client %0d, expected 2", idx); end
    request[2] = 1'b0;
    send_msg(2, 32'h00000077, 1, 1'b1);
    wait_outcome(2, 50, v, e);
    checks++; if (!v || e || result !== 16'h7700) begin errors++;
      $display("FAIL wd_recover_result: got valid=%b error=%b result=%h, expected 1/0/7700", v, e, result); end
  endtask

  task automatic test_reset_mid_stream();
    bit v, e, ok;
    int idx;
    wait_grant(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_grant: got %b, expected 0010", grant); end
    request[1] = 1'b0;
    send_msg(1, 32'h00000055, 1, 1'b0);
    checks++; if (busy !== 1'b1 || calc_data_enable !== 1'b1) begin errors++;
      $display("FAIL rst_pre_state: got busy=%b en=%b, expected 1/1", busy, calc_data_enable); end
    reset = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || result_valid !== 4'b0000 || calc_data_enable !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_clear: got grant=%b busy=%b valid=%b en=%b, expected 0000/0/0000/0",
               grant, busy, result_valid, calc_data_enable); end
    @(negedge clock);
    reset = 1'b0;
    request = 4'b1001;
    wait_any_grant(idx, ok);
    checks++; if (!ok || idx != 0) begin errors++; $display("FAIL rst_pointer: got client %0d, expected 0", idx); end
    request = 4'b0000;
    send_msg(0, 32'h00001234, 2, 1'b1);
    wait_outcome(0, 50, v, e);
    checks++; if (!v || e || result !== 16'h1234) begin errors++;
      $display("FAIL rst_recover_result: got valid=%b error=%b result=%h, expected 1/0/1234", v, e, result); end
  endtask

  initial begin
    reset = 1'b1;
    request = '0; req_data = '0; req_data_enable = '0; req_data_last = '0;
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_basic();
    test_odd_length();
    test_ignore_others();
    test_round_robin();
    test_watchdog();
    test_reset_mid_stream();
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
